// File: rtl/ioctl_ram_arb.sv
// Arbitrates the single 16-bit RAM port between the CPU and the data_io download stream.
// Download words go through a 2-entry buffer and always win arbitration over new CPU accesses.
module ioctl_ram_arb #(
  parameter int unsigned HOLD_EXTRA = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_we,
  input  logic [24:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [24:0] cpu_addr,
  input  logic [15:0] cpu_din,
  output logic [15:0] cpu_dout,
  output logic        cpu_ack,
  output logic        cpu_hold,
  output logic        mem_req,
  output logic        mem_we,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout,
  input  logic        mem_ack,
  output logic [23:0] dl_words,
  output logic        dl_done,
  output logic        dl_overflow,
  output logic [1:0]  dbg_state
);

  localparam int unsigned HW = (HOLD_EXTRA < 1) ? 1 : $clog2(HOLD_EXTRA + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_EXTRA);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DL_WR   = 2'd1,
    ST_CPU_ACC = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic        dl_meta_q, dl_s_q, dl_s_prev_q;
  logic        we_d_q;
  logic [39:0] fifo_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  cnt_q, cnt_d;
  logic        push, pop, full, accept, dl_rise;
  logic [39:0] head;

  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [23:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_din_q, mem_din_d;
  logic [15:0] cpu_dout_q;
  logic        cpu_ack_q;
  logic        cpu_hold_q;
  logic [HW-1:0] hold_cnt_q;
  logic [23:0] dl_words_q;
  logic        dl_overflow_q;
  logic        busy, busy_prev_q, seen_q;

  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, ioctl_addr[0], cpu_addr[0]};

  assign push    = ioctl_we & ~we_d_q;
  assign pop     = (state_q == ST_DL_WR) & mem_ack;
  assign full    = (cnt_q == 2'd2);
  assign accept  = push & (~full | pop);
  assign dl_rise = dl_s_q & ~dl_s_prev_q;
  assign head    = fifo_q[rd_ptr_q];
  assign busy    = dl_s_q | (cnt_q != 2'd0) | (state_q == ST_DL_WR);

  always_comb begin
    cnt_d = cnt_q;
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (accept) fifo_q[wr_ptr_q] <= {ioctl_addr[24:1], ioctl_dout};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_meta_q     <= 1'b0;
      dl_s_q        <= 1'b0;
      dl_s_prev_q   <= 1'b0;
      we_d_q        <= 1'b0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      cnt_q         <= 2'd0;
      dl_words_q    <= 24'd0;
      dl_overflow_q <= 1'b0;
      hold_cnt_q    <= '0;
      cpu_hold_q    <= 1'b0;
      busy_prev_q   <= 1'b0;
      seen_q        <= 1'b0;
    end else begin
      dl_meta_q   <= ioctl_download;
      dl_s_q      <= dl_meta_q;
      dl_s_prev_q <= dl_s_q;
      we_d_q      <= ioctl_we;
      cnt_q       <= cnt_d;
      if (accept) wr_ptr_q <= ~wr_ptr_q;
      if (pop)    rd_ptr_q <= ~rd_ptr_q;
      // A new download restarts the count; a word dropped in that same cycle still flags.
      if (dl_rise)  dl_words_q <= 24'd0;
      else if (pop) dl_words_q <= dl_words_q + 24'd1;
      if (push & full & ~pop) dl_overflow_q <= 1'b1;
      else if (dl_rise)       dl_overflow_q <= 1'b0;
      if (busy)                   hold_cnt_q <= HOLD_INIT;
      else if (hold_cnt_q != '0)  hold_cnt_q <= hold_cnt_q - 1'b1;
      cpu_hold_q  <= busy | (hold_cnt_q != '0);
      busy_prev_q <= busy;
      seen_q      <= seen_q | dl_s_q;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cnt_q != 2'd0)              state_d = ST_DL_WR;
        else if (cpu_req & ~cpu_hold_q) state_d = ST_CPU_ACC;
      end
      ST_DL_WR:   if (mem_ack) state_d = ST_IDLE;
      ST_CPU_ACC: if (mem_ack) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // RAM handshake: mem_req rises with we/addr/din already registered, all four hold
  // until the single-cycle mem_ack, and mem_req is low for at least one cycle between accesses.
  always_comb begin
    mem_req_d  = 1'b0;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    if (state_q == ST_IDLE) begin
      if (state_d == ST_DL_WR) begin
        mem_req_d  = 1'b1;
        mem_we_d   = 1'b1;
        mem_addr_d = head[39:16];
        mem_din_d  = head[15:0];
      end else if (state_d == ST_CPU_ACC) begin
        mem_req_d  = 1'b1;
        mem_we_d   = cpu_we;
        mem_addr_d = cpu_addr[24:1];
        mem_din_d  = cpu_din;
      end
    end else begin
      mem_req_d = ~mem_ack;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= 24'd0;
      mem_din_q  <= 16'd0;
      cpu_ack_q  <= 1'b0;
      cpu_dout_q <= 16'd0;
    end else begin
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      cpu_ack_q  <= (state_q == ST_CPU_ACC) & mem_ack;
      if ((state_q == ST_CPU_ACC) & mem_ack & ~mem_we_q) cpu_dout_q <= mem_dout;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;
  assign cpu_ack     = cpu_ack_q;
  assign cpu_dout    = cpu_dout_q;
  assign cpu_hold    = cpu_hold_q;
  assign dl_words    = dl_words_q;
  assign dl_overflow = dl_overflow_q;
  assign dl_done     = ~busy & busy_prev_q & seen_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ioctl_ram_arb.sv
// Directed bench for ioctl_ram_arb: download capture, buffer overflow, CPU arbitration, drain and reset.
module tb_ioctl_ram_arb;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download, ioctl_we;
  logic [24:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        cpu_req, cpu_we;
  logic [24:0] cpu_addr;
  logic [15:0] cpu_din;
  logic [15:0] cpu_dout;
  logic        cpu_ack, cpu_hold;
  logic        mem_req, mem_we;
  logic [23:0] mem_addr;
  logic [15:0] mem_din, mem_dout;
  logic        mem_ack;
  logic [23:0] dl_words;
  logic        dl_done, dl_overflow;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  ioctl_ram_arb #(.HOLD_EXTRA(4)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_we(ioctl_we),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .cpu_hold(cpu_hold),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_ack(mem_ack),
    .dl_words(dl_words), .dl_done(dl_done), .dl_overflow(dl_overflow),
    .dbg_state(dbg_state)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [24:0] a, input logic [15:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_we   = 1'b1;
    tick();
    tick();
    ioctl_we   = 1'b0;
    tick();
  endtask

  task automatic ram_ack(input logic [15:0] d);
    mem_dout = d;
    mem_ack  = 1'b1;
    tick();
    mem_ack  = 1'b0;
  endtask

  initial begin
    int n;
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_we = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    mem_dout = '0; mem_ack = 1'b0;
    #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_cpu_hold", cpu_hold, 0);
    chk("rst_dl_words", dl_words, 0);
    chk("rst_dl_overflow", dl_overflow, 0);
    chk("rst_dl_done", dl_done, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_state", dbg_state, 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // single word
    ioctl_download = 1'b1;
    tick(); tick(); tick();
    chk("t1_hold_on", cpu_hold, 1);
    ioctl_addr = 25'h0E0000; ioctl_dout = 16'hA55A; ioctl_we = 1'b1;
    tick();
    chk("t1_req_lat_n", mem_req, 0);
    tick();
    ioctl_we = 1'b0;
    chk("t1_req", mem_req, 1);
    chk("t1_we", mem_we, 1);
    chk("t1_addr", mem_addr, 24'h070000);
    chk("t1_din", mem_din, 16'hA55A);
    chk("t1_state", dbg_state, 1);
    tick(); tick();
    chk("t1_addr_stable", mem_addr, 24'h070000);
    ram_ack(16'h0);
    chk("t1_req_drop", mem_req, 0);
    chk("t1_words", dl_words, 1);
    tick(); tick(); tick();
    chk("t1_no_second", mem_req, 0);
    chk("t1_hold", cpu_hold, 1);

    // stalled RAM: A in flight, B buffered, C dropped
    push_word(25'h100, 16'h1111);
    push_word(25'h102, 16'h2222);
    push_word(25'h104, 16'hDEAD);
    chk("t2_overflow", dl_overflow, 1);
    chk("t2_a_addr", mem_addr, 24'h80);
    chk("t2_a_din", mem_din, 16'h1111);
    ram_ack(16'h0);
    chk("t2_words_a", dl_words, 2);
    tick();
    chk("t2_b_req", mem_req, 1);
    chk("t2_b_addr", mem_addr, 24'h81);
    chk("t2_b_din", mem_din, 16'h2222);
    // fill again, then push E on the same edge B is popped
    push_word(25'h106, 16'h3333);
    ioctl_addr = 25'h108; ioctl_dout = 16'h4444; ioctl_we = 1'b1;
    mem_dout = 16'h0; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("t2_words_b", dl_words, 3);
    tick();
    ioctl_we = 1'b0;
    chk("t2_d_req", mem_req, 1);
    chk("t2_d_addr", mem_addr, 24'h83);
    chk("t2_d_din", mem_din, 16'h3333);
    ram_ack(16'h0);
    chk("t2_words_d", dl_words, 4);
    tick();
    chk("t2_e_addr", mem_addr, 24'h84);
    chk("t2_e_din", mem_din, 16'h4444);
    ram_ack(16'h0);
    chk("t2_words_e", dl_words, 5);
    tick(); tick(); tick();
    chk("t2_drained", mem_req, 0);
    chk("t2_idle", dbg_state, 0);

    // end of download with one word buffered
    push_word(25'h200, 16'h5555);
    ioctl_download = 1'b0;
    tick(); tick(); tick();
    chk("t4_req", mem_req, 1);
    chk("t4_addr", mem_addr, 24'h100);
    chk("t4_din", mem_din, 16'h5555);
    chk("t4_no_done_yet", dl_done, 0);
    chk("t4_hold", cpu_hold, 1);
    ram_ack(16'h0);
    chk("t4_done", dl_done, 1);
    chk("t4_words", dl_words, 6);
    tick();
    chk("t4_done_pulse", dl_done, 0);
    tick(); tick(); tick();
    chk("t4_hold_extra", cpu_hold, 1);
    tick();
    chk("t4_hold_off", cpu_hold, 0);

    // CPU read in flight when a new download pushes a word
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h001000;
    tick();
    chk("t3_cpu_req", mem_req, 1);
    chk("t3_cpu_we", mem_we, 0);
    chk("t3_cpu_addr", mem_addr, 24'h000800);
    chk("t3_state", dbg_state, 2);
    ioctl_download = 1'b1;
    ioctl_addr = 25'h300; ioctl_dout = 16'h6666; ioctl_we = 1'b1;
    tick(); tick();
    ioctl_we = 1'b0;
    chk("t3_no_preempt", mem_addr, 24'h000800);
    tick();
    ram_ack(16'hBEEF);
    chk("t3_cpu_ack", cpu_ack, 1);
    chk("t3_cpu_dout", cpu_dout, 16'hBEEF);
    cpu_req = 1'b0;
    tick();
    chk("t3_ack_pulse", cpu_ack, 0);
    chk("t3_dl_req", mem_req, 1);
    chk("t3_dl_we", mem_we, 1);
    chk("t3_dl_addr", mem_addr, 24'h180);
    chk("t3_words_clr", dl_words, 0);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 25'h2002; cpu_din = 16'h7777;
    ram_ack(16'h0);
    chk("t3_words", dl_words, 1);
    ioctl_download = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      n = i;
      if (mem_req) break;
    end
    if (!mem_req) n = 21;
    chk("t3_stall_cycles", n, 8);
    chk("t3_wr_we", mem_we, 1);
    chk("t3_wr_addr", mem_addr, 24'h1001);
    chk("t3_wr_din", mem_din, 16'h7777);
    ram_ack(16'h1234);
    chk("t3_wr_ack", cpu_ack, 1);
    chk("t3_wr_dout_kept", cpu_dout, 16'hBEEF);
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();

    // reset during DL_WR
    ioctl_download = 1'b1;
    tick(); tick(); tick();
    push_word(25'h400, 16'h8888);
    ram_ack(16'h0);
    chk("t5_words", dl_words, 1);
    tick();
    push_word(25'h402, 16'h9999);
    chk("t5_inflight", mem_req, 1);
    chk("t5_state_dl", dbg_state, 1);
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    #1;
    chk("t5_rst_req", mem_req, 0);
    chk("t5_rst_hold", cpu_hold, 0);
    chk("t5_rst_words", dl_words, 0);
    chk("t5_rst_state", dbg_state, 0);
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    chk("t5_post_req", mem_req, 0);
    chk("t5_post_state", dbg_state, 0);
    chk("t5_post_hold", cpu_hold, 0);
    chk("t5_post_ack", cpu_ack, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
